// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive FIFO sitting between a UART receiver and a register block. Each entry
// carries a received character together with its framing and parity error
// flags. The head entry is presented show-ahead so the register block can read
// it without waiting. Also provides a watermark trigger, a sticky overflow flag
// and an optional idle-timeout flag.
//
// Optional feature macro: UART_RX_TIMEOUT_EN
//   defined   -> 16-bit idle counter drives tout_o against to_cycles_i
//   undefined -> no counter, tout_o tied low, to_cycles_i ignored
//
// Parameters
//   DEPTH        number of entries (power of two, 4..256)
//   AW           pointer width, log2(DEPTH)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   push_i       receiver strobe, byte_i/ferr_i/perr_i valid this cycle
//   byte_i       received character
//   ferr_i       framing error flag of byte_i
//   perr_i       parity error flag of byte_i
//   pull_i       pop the head entry
//   flush_i      synchronous clear of the contents (wins over push/pull)
//   wm_i         watermark; trig_o is high while level > wm_i
//   ovf_clr_i    clears the sticky overflow flag
//   to_cycles_i  idle-timeout length in clk cycles (0 disables)
//   byte_o       head character (0 while empty)
//   ferr_o       head framing error flag
//   perr_o       head parity error flag
//   empty_o      no entries held
//   full_o       DEPTH entries held
//   level_o      entry count 0..DEPTH
//   trig_o       watermark trigger (registered)
//   ovf_o        sticky overflow flag
//   tout_o       idle-timeout flag
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [7:0]    byte_i,
  input  logic          ferr_i,
  input  logic          perr_i,
  input  logic          pull_i,
  input  logic          flush_i,
  input  logic [AW-1:0] wm_i,
  input  logic          ovf_clr_i,
  input  logic [15:0]   to_cycles_i,
  output logic [7:0]    byte_o,
  output logic          ferr_o,
  output logic          perr_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   level_o,
  output logic          trig_o,
  output logic          ovf_o,
  output logic          tout_o
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  // Entry layout: {perr, ferr, byte}
  logic [9:0]    mem_q [DEPTH];
  logic [9:0]    head;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          trig_q, trig_d;
  logic          ovf_q, ovf_d;

  logic          empty, full;
  logic          do_push, do_pull, ovf_set;

  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == FULL_LVL);
    // A push into a full FIFO is still accepted when a pull frees the slot in
    // the same cycle. A pull on an empty FIFO is ignored, so push+pull while
    // empty degenerates to a plain push.
    do_push = push_i & ~flush_i & (~full | pull_i);
    do_pull = pull_i & ~flush_i & ~empty;
    // A push discarded by flush is not an overflow.
    ovf_set = push_i & ~flush_i & full & ~pull_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is 2**AW.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pull) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pull})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end

    // Trigger follows the next-state level so it moves with level_o.
    trig_d = (level_d > {1'b0, wm_i});
    // Set wins over clear when both happen in the same cycle.
    ovf_d  = (ovf_q & ~ovf_clr_i) | ovf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      trig_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      trig_q   <= trig_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {perr_i, ferr_i, byte_i};
  end

  // Asynchronous show-ahead read: the entry written on an edge is visible as
  // soon as level_q leaves zero on that same edge. Outputs are forced to zero
  // while empty so reset presents a clean, defined head.
  always_comb begin
    head = empty ? 10'd0 : mem_q[rd_ptr_q];
  end

  assign byte_o  = head[7:0];
  assign ferr_o  = head[8];
  assign perr_o  = head[9];
  assign empty_o = empty;
  assign full_o  = full;
  assign level_o = level_q;
  assign trig_o  = trig_q;
  assign ovf_o   = ovf_q;

`ifdef UART_RX_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;
  logic        tout_q, tout_d;

  always_comb begin
    idle_d = idle_q;
    tout_d = tout_q;
    // Count only while characters sit unserviced; saturate instead of wrapping
    // so a long idle period cannot re-arm a spurious match.
    if (push_i | pull_i | flush_i | empty) begin
      idle_d = '0;
    end else if (idle_q != 16'hFFFF) begin
      idle_d = idle_q + 1'b1;
    end
    if (push_i | pull_i | flush_i) begin
      tout_d = 1'b0;
    end else if ((to_cycles_i != 16'd0) && (idle_d == to_cycles_i)) begin
      tout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
      tout_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      tout_q <= tout_d;
    end
  end

  assign tout_o = tout_q;
`else
  logic unused_to_cycles;
  assign unused_to_cycles = ^to_cycles_i;
  assign tout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Self-checking bench for uart_rx_fifo (DEPTH=16). A table of single-cycle
// operations with expected level/trigger is applied first, followed by
// hand-written sequences for overflow, full push+pull, overflow-vs-clear,
// flush with push, asynchronous reset and (when UART_RX_TIMEOUT_EN is defined)
// the idle timeout. A queue scoreboard holds the expected FIFO contents; heads
// are compared whenever a pull is accepted.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push_i = 1'b0;
  logic [7:0]    byte_i = 8'd0;
  logic          ferr_i = 1'b0;
  logic          perr_i = 1'b0;
  logic          pull_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [AW-1:0] wm_i = 4'd3;
  logic          ovf_clr_i = 1'b0;
  logic [15:0]   to_cycles_i = 16'd40;
  logic [7:0]    byte_o;
  logic          ferr_o;
  logic          perr_o;
  logic          empty_o;
  logic          full_o;
  logic [AW:0]   level_o;
  logic          trig_o;
  logic          ovf_o;
  logic          tout_o;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .push_i(push_i), .byte_i(byte_i),
    .ferr_i(ferr_i), .perr_i(perr_i), .pull_i(pull_i), .flush_i(flush_i),
    .wm_i(wm_i), .ovf_clr_i(ovf_clr_i), .to_cycles_i(to_cycles_i),
    .byte_o(byte_o), .ferr_o(ferr_o), .perr_o(perr_o), .empty_o(empty_o),
    .full_o(full_o), .level_o(level_o), .trig_o(trig_o), .ovf_o(ovf_o),
    .tout_o(tout_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0] sb_q[$];
  bit         m_ovf = 1'b0;

  typedef struct {
    bit         pu;
    bit         pl;
    bit         fl;
    logic [7:0] b;
    bit         fe;
    bit         pe;
    int         lvl;
    bit         trg;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus. Called at posedge+1; heads are compared before the
  // edge, state outputs after it.
  task automatic step(input bit pu, input bit pl, input bit fl, input logic [7:0] b,
                      input bit fe, input bit pe, input bit clr);
    bit         was_full;
    bit         popped;
    logic [9:0] hd;
    push_i = pu; pull_i = pl; flush_i = fl; byte_i = b;
    ferr_i = fe; perr_i = pe; ovf_clr_i = clr;
    was_full = (sb_q.size() == DEPTH);
    popped   = 1'b0;
    if (fl) begin
      sb_q.delete();
    end else begin
      if (pl && sb_q.size() > 0) begin
        hd = sb_q.pop_front();
        chk("head_byte", 32'(byte_o), 32'(hd[7:0]));
        chk("head_ferr", 32'(ferr_o), 32'(hd[8]));
        chk("head_perr", 32'(perr_o), 32'(hd[9]));
        popped = 1'b1;
      end
      if (pu && (!was_full || popped)) sb_q.push_back({pe, fe, b});
    end
    m_ovf = (m_ovf && !clr) || (pu && !fl && was_full && !pl);
    @(posedge clk);
    #1;
    push_i = 1'b0; pull_i = 1'b0; flush_i = 1'b0; ovf_clr_i = 1'b0;
    ferr_i = 1'b0; perr_i = 1'b0;
    chk("level", 32'(level_o), 32'(sb_q.size()));
    chk("empty", 32'(empty_o), 32'(sb_q.size() == 0));
    chk("full",  32'(full_o),  32'(sb_q.size() == DEPTH));
    chk("trig",  32'(trig_o),  32'(sb_q.size() > int'(wm_i)));
    chk("ovf",   32'(ovf_o),   32'(m_ovf));
`ifndef UART_RX_TIMEOUT_EN
    chk("tout_off", 32'(tout_o), 32'd0);
`endif
    $display("step pu=%0d pl=%0d fl=%0d b=%02h -> level=%0d trig=%0d ovf=%0d head=%02h",
             pu, pl, fl, b, level_o, trig_o, ovf_o, byte_o);
  endtask

  initial begin
    vt[0]  = '{1, 0, 0, 8'h41, 0, 0, 1, 0};
    vt[1]  = '{1, 0, 0, 8'h42, 0, 0, 2, 0};
    vt[2]  = '{1, 0, 0, 8'h43, 0, 0, 3, 0};
    vt[3]  = '{0, 1, 0, 8'h00, 0, 0, 2, 0};
    vt[4]  = '{0, 1, 0, 8'h00, 0, 0, 1, 0};
    vt[5]  = '{0, 1, 0, 8'h00, 0, 0, 0, 0};
    vt[6]  = '{0, 1, 0, 8'h00, 0, 0, 0, 0};
    vt[7]  = '{1, 1, 0, 8'h7E, 1, 0, 1, 0};
    vt[8]  = '{1, 0, 0, 8'h01, 0, 1, 2, 0};
    vt[9]  = '{1, 0, 0, 8'h02, 0, 0, 3, 0};
    vt[10] = '{1, 0, 0, 8'h03, 0, 0, 4, 1};
    vt[11] = '{0, 1, 0, 8'h00, 0, 0, 3, 0};
    vt[12] = '{1, 1, 0, 8'h04, 0, 0, 3, 0};
    vt[13] = '{1, 0, 1, 8'h99, 0, 0, 0, 0};

    // Reset state
    #12;
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full",  32'(full_o),  32'd0);
    chk("rst_trig",  32'(trig_o),  32'd0);
    chk("rst_ovf",   32'(ovf_o),   32'd0);
    chk("rst_tout",  32'(tout_o),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven basic operation
    for (int i = 0; i < 14; i++) begin
      step(vt[i].pu, vt[i].pl, vt[i].fl, vt[i].b, vt[i].fe, vt[i].pe, 1'b0);
      chk("tbl_level", 32'(level_o), 32'(vt[i].lvl));
      chk("tbl_trig",  32'(trig_o),  32'(vt[i].trg));
    end

    // Overflow: 17 pushes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      step(1, 0, 0, 8'(i), 0, 0, 1'b0);
      if (i == 15) chk("full_after_16", 32'(full_o), 32'd1);
      if (i == 15) chk("no_ovf_at_16", 32'(ovf_o), 32'd0);
    end
    chk("ovf_after_17", 32'(ovf_o), 32'd1);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00, 0, 0, 1'b0);
    chk("drained_empty", 32'(empty_o), 32'd1);
    step(0, 0, 0, 8'h00, 0, 0, 1'b1);
    chk("ovf_cleared", 32'(ovf_o), 32'd0);

    // Full: push+pull together keeps the level and queues 0x55 last
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'h80 + 8'(i), 0, 0, 1'b0);
    step(1, 1, 0, 8'h55, 0, 0, 1'b0);
    chk("full_pp_level", 32'(level_o), 32'd16);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 8'h00, 0, 0, 1'b0);
    chk("last_is_55", 32'(byte_o), 32'h55);
    step(0, 1, 0, 8'h00, 0, 0, 1'b0);

    // Overflow and clear in the same cycle: overflow wins
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'h20 + 8'(i), 0, 0, 1'b0);
    step(1, 0, 0, 8'hEE, 0, 0, 1'b0);
    step(1, 0, 0, 8'hEF, 0, 0, 1'b1);
    chk("ovf_set_beats_clr", 32'(ovf_o), 32'd1);
    // Flush with push: empties, ovf untouched
    step(1, 0, 1, 8'hAB, 0, 0, 1'b0);
    chk("flush_level", 32'(level_o), 32'd0);
    chk("flush_empty", 32'(empty_o), 32'd1);
    chk("flush_ovf",   32'(ovf_o),   32'd1);

    // Asynchronous reset mid-burst
    step(1, 0, 0, 8'hFF, 1, 1, 1'b0);
    step(1, 0, 0, 8'h11, 0, 0, 1'b0);
    step(1, 0, 0, 8'h22, 0, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("amid_level", 32'(level_o), 32'd0);
    chk("amid_empty", 32'(empty_o), 32'd1);
    chk("amid_full",  32'(full_o),  32'd0);
    chk("amid_trig",  32'(trig_o),  32'd0);
    chk("amid_ovf",   32'(ovf_o),   32'd0);
    chk("amid_tout",  32'(tout_o),  32'd0);
    chk("amid_byte",  32'(byte_o),  32'd0);
    chk("amid_ferr",  32'(ferr_o),  32'd0);
    chk("amid_perr",  32'(perr_o),  32'd0);
    $display("async reset mid-burst -> level=%0d ovf=%0d byte=%02h", level_o, ovf_o, byte_o);
    sb_q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 0, 0, 8'h5A, 0, 0, 1'b0);
    step(0, 1, 0, 8'h00, 0, 0, 1'b0);

`ifdef UART_RX_TIMEOUT_EN
    begin
      int n;
      n = 0;
      step(1, 0, 0, 8'hC3, 0, 0, 1'b0);
      for (int i = 1; i <= 100; i++) begin
        @(posedge clk);
        #1;
        if (tout_o) begin
          n = i;
          break;
        end
      end
      chk("tout_cycles", 32'(n), 32'd40);
      $display("timeout flagged after %0d idle cycles", n);
      step(0, 1, 0, 8'h00, 0, 0, 1'b0);
      chk("tout_cleared", 32'(tout_o), 32'd0);
    end
`else
    begin
      step(1, 0, 0, 8'hC3, 0, 0, 1'b0);
      repeat (60) @(posedge clk);
      #1;
      chk("tout_disabled", 32'(tout_o), 32'd0);
      step(0, 1, 0, 8'h00, 0, 0, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16: number of entries; SHALL be a power of two, 4..256.
REQ-002 Parameter AW, default 4: pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  in  1  system clock; all state SHALL be updated on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 push_i  in  1  receiver strobe: one received character is presented this cycle.
REQ-006 byte_i  in  8  received character.
REQ-007 ferr_i  in  1  framing error flag for byte_i.
REQ-008 perr_i  in  1  parity error flag for byte_i.
REQ-009 pull_i  in  1  register-block read strobe: pop the head entry.
REQ-010 flush_i  in  1  synchronous clear of the FIFO contents.
REQ-011 wm_i  in  AW  trigger watermark.
REQ-012 ovf_clr_i  in  1  clears the overflow flag.
REQ-013 to_cycles_i  in  16  idle-timeout length in clk cycles.
REQ-014 byte_o  out  8  head character, show-ahead.
REQ-015 ferr_o  out  1  framing error flag of the head character.
REQ-016 perr_o  out  1  parity error flag of the head character.
REQ-017 empty_o  out  1  FIFO holds 0 entries.
REQ-018 full_o  out  1  FIFO holds DEPTH entries.
REQ-019 level_o  out  AW+1  current entry count, 0..DEPTH.
REQ-020 trig_o  out  1  watermark trigger.
REQ-021 ovf_o  out  1  sticky overflow flag.
REQ-022 tout_o  out  1  idle-timeout flag.

Function
REQ-023 Storage: each entry SHALL hold 10 bits {perr, ferr, byte}; read and write pointers are AW bits wide and wrap from DEPTH-1 to 0; the count is a registered AW+1-bit counter.
REQ-024 Push while not full: the entry SHALL be written; level_o increments in the next cycle.
REQ-025 Pull while not empty: the read pointer SHALL advance; level_o decrements in the next cycle.
REQ-026 byte_o, ferr_o and perr_o SHALL present the head entry whenever empty_o=0, with zero latency from the write; their value is don't-care while empty_o=1.
REQ-027 Pull while empty SHALL be ignored, with no pointer or level change.
REQ-028 Push while full and without pull: the character SHALL be dropped, and ovf_o SHALL set on the next edge.
REQ-029 Push and pull together while full: both SHALL be performed and level_o stays DEPTH.
REQ-030 Push and pull together while empty: only the push SHALL take effect and level_o becomes 1.
REQ-031 Push and pull together in any other state: both SHALL be performed and level_o is unchanged.
REQ-032 Flush: flush_i SHALL have priority over push and pull in the same cycle; pointers and level go to 0 and any simultaneous push is discarded without setting ovf_o.
REQ-033 ovf_o SHALL stay set until ovf_clr_i; if ovf_clr_i and a new overflow occur in the same cycle, ovf_o SHALL remain 1.
REQ-034 trig_o SHALL be registered and equal 1 when the next-state level is greater than wm_i, so trig_o is updated in the same cycle as level_o.
REQ-035 empty_o and full_o SHALL be decoded from the registered level: empty_o when level is 0, full_o when level is DEPTH.

Reset
REQ-036 While rst_n=0: pointers=0, level_o=0, empty_o=1, full_o=0, trig_o=0, ovf_o=0, tout_o=0, byte_o/ferr_o/perr_o=0; the storage array is not reset.
REQ-037 Reset asserted mid-operation SHALL discard all contents immediately and asynchronously.

Configuration
REQ-038 With UART_RX_TIMEOUT_EN defined, a 16-bit idle counter SHALL increment each cycle while the FIFO is non-empty and no push or pull occurs.
REQ-039 The idle counter SHALL clear on any push, pull, flush, or when the FIFO is empty.
REQ-040 tout_o SHALL set when the idle counter reaches to_cycles_i, with to_cycles_i nonzero, and SHALL clear on the next pull, flush or push.
REQ-041 Without UART_RX_TIMEOUT_EN, no counter SHALL be present, tout_o is tied to 0, and to_cycles_i is unused.

Verification
REQ-042 Push 0x41, 0x42, 0x43 -> level_o=3, byte_o=0x41; after three pulls byte_o shows 0x42, then 0x43, then empty_o=1.
REQ-043 With DEPTH=16, push 17 bytes -> full_o=1 after the 16th push, ovf_o=1 after the 17th, and the 17th byte is absent when the FIFO is drained; ovf_clr_i -> ovf_o=0.
REQ-044 With the FIFO full, push 0x55 and pull together -> level_o stays 16 and 0x55 is read last; with the FIFO empty, push and pull together -> level_o=1.
REQ-045 wm_i=3: the 4th push sets trig_o=1; a single pull clears it; flush together with push -> level_o=0, empty_o=1, ovf_o unchanged.
REQ-046 Push byte 0x7E with ferr_i=1 and perr_i=0 -> ferr_o=1, perr_o=0 at the head; reset asserted mid-burst -> all outputs at their reset values before the next edge.
REQ-047 UART_RX_TIMEOUT_EN with to_cycles_i=40: one push then idle -> tout_o=1 after 40 cycles; pull -> tout_o=0; without the macro, tout_o stays 0.
